// File: rtl/sramlike_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sramlike_arbiter_pkg
// Shared definitions for the sram-like two-into-one arbiter:
//   - sel_e        : requester encoding (SEL_INST = 0, SEL_DATA = 1)
//   - lock_state_e : grant-lock state of the arbiter
//   - OUTST_DEPTH_DEF / ADDR_W_DEF : parameter defaults used by all files
// ---------------------------------------------------------------------------
package sramlike_arbiter_pkg;

  localparam int OUTST_DEPTH_DEF = 4;
  localparam int ADDR_W_DEF      = 32;

  typedef enum logic {
    SEL_INST = 1'b0,
    SEL_DATA = 1'b1
  } sel_e;

  typedef enum logic {
    LK_IDLE = 1'b0,   // free to arbitrate
    LK_HELD = 1'b1    // request issued but not yet accepted; grant frozen
  } lock_state_e;

endpackage

// File: rtl/sramlike_arbiter_if.sv
// ---------------------------------------------------------------------------
// sramlike_arbiter_if
// One sram-like port: request payload travelling master -> slave, and the
// addr_ok / data_ok / rdata responses travelling slave -> master.
//   master : drives req, wr, size, addr, wstrb, wdata; receives rdata,
//            addr_ok, data_ok
//   slave  : the mirror image
// Parameter ADDR_W sets both address and data width.
// ---------------------------------------------------------------------------
interface sramlike_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output rdata, addr_ok, data_ok
  );

endinterface

// File: rtl/sramlike_arbiter_order_fifo.sv
// ---------------------------------------------------------------------------
// arb_order_fifo
// Remembers which requester owns each accepted-but-unanswered transaction so
// that in-order data_ok responses can be routed back to the right side.
// Ports:
//   clk, reset    : clock, synchronous active-high reset (empties the FIFO)
//   push, din     : enqueue one owner tag (ignored while full)
//   pop           : dequeue the head (ignored while empty)
//   dout          : owner tag at the head
//   full, empty   : occupancy flags
// Occupancy is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and
// wrap naturally because DEPTH is a power of two.
// ---------------------------------------------------------------------------
module arb_order_fifo
  import sramlike_arbiter_pkg::*;
#(
  parameter int DEPTH = OUTST_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  sel_e din,
  input  logic pop,
  output sel_e dout,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sel_e             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the count unchanged.
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, and the pointers/count carry validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// ---------------------------------------------------------------------------
// sramlike_arbiter
// Merges an instruction-side and a data-side sram-like requester onto one
// sram-like master port (toward a shared AXI bridge). Request and response
// paths are purely combinational; the only state is the grant lock, the
// round-robin history (optional) and the in-order owner FIFO.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high; while high, m.req and every
//           addr_ok/data_ok are forced to 0
//   inst  : instruction requester (slave modport, reads only; inst.wr unused)
//   data  : data requester (slave modport)
//   m     : merged master port (master modport); responses arrive in
//           acceptance order
// Parameters:
//   OUTST_DEPTH : max accepted-but-unanswered transactions (power of 2, 2..16)
//   ADDR_W      : address / data width
// Build option:
//   ARB_ROUND_ROBIN_EN : when defined, an unlocked tie goes to the side that
//                        did not win the previous handshake; otherwise data
//                        has fixed priority over inst.
// ---------------------------------------------------------------------------
module sramlike_arbiter
  import sramlike_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = OUTST_DEPTH_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  sramlike_arbiter_if.slave   inst,
  sramlike_arbiter_if.slave   data,
  sramlike_arbiter_if.master  m
);

  sel_e              sel;
  sel_e              lock_sel;
  sel_e              lock_sel_nx;
  lock_state_e       lock_state;
  lock_state_e       lock_state_nx;
  sel_e              head_sel;
  logic              fifo_full;
  logic              fifo_empty;
  logic              m_req_int;
  logic              handshake;
  logic              resp_pop;
  logic [ADDR_W-1:0] rdata_fwd;

`ifdef ARB_ROUND_ROBIN_EN
  sel_e              rr_last;
`endif

  // -------------------------------------------------------------------------
  // Grant selection. A held lock freezes the grant so the payload presented
  // to the bridge cannot change between request and acceptance.
  // -------------------------------------------------------------------------
  // NOTE: every combinational output is given a default first so that no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    sel = SEL_INST;
    if (lock_state == LK_HELD) begin
      sel = lock_sel;
    end else if (inst.req && data.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      sel = (rr_last == SEL_DATA) ? SEL_INST : SEL_DATA;
`else
      sel = SEL_DATA;
`endif
    end else if (data.req) begin
      sel = SEL_DATA;
    end
  end

  // A full order FIFO blocks new requests even if a pop lands this cycle,
  // which keeps the full path free of a data_ok -> m.req combinational loop.
  assign m_req_int = (inst.req | data.req) & ~fifo_full & ~reset;
  assign handshake = m_req_int & m.addr_ok;
  assign resp_pop  = m.data_ok & ~fifo_empty & ~reset;

  // -------------------------------------------------------------------------
  // Grant lock: two-process FSM.
  // -------------------------------------------------------------------------
  always_comb begin
    lock_state_nx = lock_state;
    lock_sel_nx   = lock_sel;
    unique case (lock_state)
      LK_IDLE: begin
        if (m_req_int && !m.addr_ok) begin
          lock_state_nx = LK_HELD;
          lock_sel_nx   = sel;
        end
      end
      LK_HELD: begin
        // Held until acceptance, even if the owner has dropped its req.
        if (handshake) lock_state_nx = LK_IDLE;
      end
      default: lock_state_nx = LK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_state <= LK_IDLE;
      lock_sel   <= SEL_INST;
    end else begin
      lock_state <= lock_state_nx;
      lock_sel   <= lock_sel_nx;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Starts at data so that inst wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= SEL_DATA;
    end else if (handshake) begin
      rr_last <= sel;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Owner FIFO: one tag per accepted request, popped per data_ok.
  // -------------------------------------------------------------------------
  arb_order_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_order_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (handshake),
    .din   (sel),
    .pop   (resp_pop),
    .dout  (head_sel),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // -------------------------------------------------------------------------
  // Request path to the bridge.
  // -------------------------------------------------------------------------
  always_comb begin
    m.req   = m_req_int;
    m.wr    = 1'b0;
    m.size  = inst.size;
    m.addr  = inst.addr;
    m.wstrb = inst.wstrb;
    m.wdata = inst.wdata;
    if (sel == SEL_DATA) begin
      m.wr    = data.wr;
      m.size  = data.size;
      m.addr  = data.addr;
      m.wstrb = data.wstrb;
      m.wdata = data.wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Response path back to the requesters.
  // -------------------------------------------------------------------------
  assign rdata_fwd    = m.rdata;
  assign inst.rdata   = rdata_fwd;
  assign data.rdata   = rdata_fwd;

  assign inst.addr_ok = handshake & (sel == SEL_INST);
  assign data.addr_ok = handshake & (sel == SEL_DATA);
  assign inst.data_ok = resp_pop & (head_sel == SEL_INST);
  assign data.data_ok = resp_pop & (head_sel == SEL_DATA);

endmodule

// File: tb/tb_sramlike_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sramlike_arbiter
// Directed bench for sramlike_arbiter (OUTST_DEPTH = 4, ADDR_W = 32).
// Inputs change 1 ns after a rising edge; combinational outputs are sampled
// 1 ns later, registered state 1 ns after the edge that updates it.
// Handshake bundle hs = {inst.addr_ok, data.addr_ok, inst.data_ok,
// data.data_ok}.
// ---------------------------------------------------------------------------
module tb_sramlike_arbiter;
  import sramlike_arbiter_pkg::*;

  localparam logic [31:0] INST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sramlike_arbiter_if #(.ADDR_W(32)) inst_if ();
  sramlike_arbiter_if #(.ADDR_W(32)) data_if ();
  sramlike_arbiter_if #(.ADDR_W(32)) m_if ();

  sramlike_arbiter #(
    .OUTST_DEPTH (4),
    .ADDR_W      (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .m     (m_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] hs_now();
    return {inst_if.addr_ok, data_if.addr_ok, inst_if.data_ok, data_if.data_ok};
  endfunction

  task automatic idle();
    inst_if.req   = 1'b0;
    inst_if.wr    = 1'b0;
    inst_if.size  = 2'd2;
    inst_if.addr  = INST_PC;
    inst_if.wstrb = 4'h0;
    inst_if.wdata = '0;
    data_if.req   = 1'b0;
    data_if.wr    = 1'b0;
    data_if.size  = 2'd2;
    data_if.addr  = 32'h8000_0000;
    data_if.wstrb = 4'hF;
    data_if.wdata = 32'h1234_5678;
    m_if.rdata    = '0;
    m_if.addr_ok  = 1'b0;
    m_if.data_ok  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Pops one response and checks it is routed to the expected owner.
  task automatic drain_one(input string tag, input sel_e owner,
                           input logic [31:0] rd);
    m_if.data_ok = 1'b1;
    m_if.rdata   = rd;
    settle();
    check({tag, "_hs"}, hs_now(), (owner == SEL_INST) ? 4'b0010 : 4'b0001);
    check({tag, "_rd"}, (owner == SEL_INST) ? inst_if.rdata : data_if.rdata, rd);
    next_cycle();
    m_if.data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout n_checks=%0d", n_checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    sel_e exp_q[$];

    // ---------------- reset gating ----------------
    reset = 1'b1;
    idle();
    inst_if.req  = 1'b1;
    data_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    m_if.data_ok = 1'b1;
    next_cycle();
    settle();
    check("rst_m_req", m_if.req, 0);
    check("rst_hs", hs_now(), 4'b0000);
    next_cycle();
    reset = 1'b0;
    idle();
    check("rst_occ", dut.u_order_fifo.count_q, 0);
    check("rst_lock", dut.lock_state, LK_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    // ---------------- round-robin tie: I, D, I, D ----------------
    for (int i = 0; i < 4; i++) begin
      inst_if.req  = 1'b1;
      data_if.req  = 1'b1;
      data_if.wr   = 1'b1;
      data_if.addr = 32'h8000_0010 + 32'(i);
      m_if.addr_ok = 1'b1;
      settle();
      check("rr_hs", hs_now(), (i % 2 == 0) ? 4'b1000 : 4'b0100);
      check("rr_addr", m_if.addr, (i % 2 == 0) ? INST_PC : 32'h8000_0010 + 32'(i));
      next_cycle();
    end
    exp_q = '{SEL_INST, SEL_DATA, SEL_INST, SEL_DATA};
`else
    // ---------------- fixed priority: data wins every tie ----------------
    for (int i = 0; i < 3; i++) begin
      inst_if.req  = 1'b1;
      data_if.req  = 1'b1;
      data_if.wr   = 1'b1;
      data_if.addr = 32'h8000_0010 + 32'(i);
      m_if.addr_ok = 1'b1;
      settle();
      check("fp_m_req", m_if.req, 1);
      check("fp_hs", hs_now(), 4'b0100);
      check("fp_addr", m_if.addr, 32'h8000_0010 + 32'(i));
      check("fp_wr", m_if.wr, 1);
      next_cycle();
    end
    data_if.req = 1'b0;
    settle();
    check("fp_inst_hs", hs_now(), 4'b1000);
    check("fp_inst_wr", m_if.wr, 0);
    check("fp_inst_addr", m_if.addr, INST_PC);
    next_cycle();
    exp_q = '{SEL_DATA, SEL_DATA, SEL_DATA, SEL_INST};
`endif
    check("tie_occ", dut.u_order_fifo.count_q, 4);

    // Full: a further request is blocked, also on a same-cycle pop.
    inst_if.req = 1'b1;
    data_if.req = 1'b0;
    settle();
    check("full_m_req", m_if.req, 0);
    check("full_hs", hs_now(), 4'b0000);
    next_cycle();
    m_if.data_ok = 1'b1;
    m_if.rdata   = 32'hA0;
    settle();
    check("full_pop_m_req", m_if.req, 0);
    check("full_pop_hs", hs_now(), (exp_q[0] == SEL_INST) ? 4'b0010 : 4'b0001);
    next_cycle();
    void'(exp_q.pop_front());
    idle();
    check("full_pop_occ", dut.u_order_fifo.count_q, 3);
    for (int i = 0; i < 3; i++) drain_one("tie_drain", exp_q[i], 32'hA1 + 32'(i));
    check("tie_drain_occ", dut.u_order_fifo.count_q, 0);

    // ---------------- ordered accepts I, D, D, I then full ----------------
    exp_q = '{SEL_INST, SEL_DATA, SEL_DATA, SEL_INST};
    foreach (exp_q[i]) begin
      idle();
      inst_if.req  = (exp_q[i] == SEL_INST);
      data_if.req  = (exp_q[i] == SEL_DATA);
      m_if.addr_ok = 1'b1;
      settle();
      check("ord_hs", hs_now(), (exp_q[i] == SEL_INST) ? 4'b1000 : 4'b0100);
      next_cycle();
    end
    idle();
    inst_if.req  = 1'b1;
    data_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    settle();
    check("ord_5th_m_req", m_if.req, 0);
    check("ord_5th_hs", hs_now(), 4'b0000);
    next_cycle();
    idle();
    foreach (exp_q[i]) drain_one("ord_drain", exp_q[i], 32'hC0DE_0000 + 32'(i));
    check("ord_occ", dut.u_order_fifo.count_q, 0);

    // ---------------- lock holds inst while data rises ----------------
    for (int i = 0; i < 3; i++) begin
      inst_if.req  = 1'b1;
      data_if.req  = (i > 0);
      m_if.addr_ok = 1'b0;
      settle();
      check("lock_addr", m_if.addr, INST_PC);
      check("lock_wr", m_if.wr, 0);
      check("lock_hs", hs_now(), 4'b0000);
      next_cycle();
    end
    check("lock_held", dut.lock_state, LK_HELD);
    m_if.addr_ok = 1'b1;
    settle();
    check("lock_accept_hs", hs_now(), 4'b1000);
    check("lock_accept_addr", m_if.addr, INST_PC);
    next_cycle();
    inst_if.req = 1'b0;
    settle();
    check("lock_data_hs", hs_now(), 4'b0100);
    next_cycle();
    idle();
    check("lock_occ", dut.u_order_fifo.count_q, 2);
    drain_one("lock_drain0", SEL_INST, 32'h11);
    drain_one("lock_drain1", SEL_DATA, 32'h22);

    // ---------------- push + pop same cycle, spurious data_ok ----------------
    inst_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    next_cycle();
    idle();
    check("pp_occ1", dut.u_order_fifo.count_q, 1);
    data_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    m_if.data_ok = 1'b1;
    m_if.rdata   = 32'h33;
    settle();
    check("pp_hs", hs_now(), 4'b0110);
    check("pp_rd", inst_if.rdata, 32'h33);
    next_cycle();
    idle();
    check("pp_occ_same", dut.u_order_fifo.count_q, 1);
    drain_one("pp_drain", SEL_DATA, 32'h44);
    check("pp_occ0", dut.u_order_fifo.count_q, 0);
    m_if.data_ok = 1'b1;
    settle();
    check("spur_hs", hs_now(), 4'b0000);
    next_cycle();
    idle();
    check("spur_occ", dut.u_order_fifo.count_q, 0);

    // ---------------- reset with 3 outstanding and a held lock ----------------
    inst_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) next_cycle();
    inst_if.req  = 1'b0;
    data_if.req  = 1'b1;
    m_if.addr_ok = 1'b0;
    next_cycle();
    check("mid_occ", dut.u_order_fifo.count_q, 3);
    check("mid_lock", dut.lock_state, LK_HELD);
    reset        = 1'b1;
    m_if.addr_ok = 1'b1;
    m_if.data_ok = 1'b1;
    settle();
    check("mid_rst_m_req", m_if.req, 0);
    check("mid_rst_hs", hs_now(), 4'b0000);
    next_cycle();
    reset = 1'b0;
    idle();
    check("post_rst_occ", dut.u_order_fifo.count_q, 0);
    check("post_rst_lock", dut.lock_state, LK_IDLE);
    m_if.data_ok = 1'b1;
    settle();
    check("post_rst_spur_hs", hs_now(), 4'b0000);
    next_cycle();
    idle();

    // ---------------- owner drops req while locked ----------------
    inst_if.req  = 1'b1;
    m_if.addr_ok = 1'b0;
    next_cycle();
    inst_if.req  = 1'b0;
    data_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    settle();
    check("drop_hs", hs_now(), 4'b1000);
    check("drop_addr", m_if.addr, INST_PC);
    next_cycle();
    idle();
    drain_one("drop_drain", SEL_INST, 32'h55);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
